// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 keystream consumer stages.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } sx_state_e;

  localparam int KS_DEPTH_DEF = 4;

endpackage

// File: rtl/rc4_ks_fifo.sv
// Register-based keystream byte FIFO; registered head, level, full and empty.
// Push while full and pop while empty are ignored; push+pop together keep the level.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int  DEPTH = KS_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  byte_t         wr_data,
  input  logic          pop,
  output byte_t         rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  byte_t         mem_q [DEPTH];
  byte_t         mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are AW bits wide so they wrap modulo DEPTH for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/rc4_stream_xor.sv
// XORs a length-programmed byte stream with buffered RC4 keystream; one cycle din-to-dout.
// din stalls while the keystream FIFO is empty or a held dout byte is not taken.
module rc4_stream_xor
  import rc4_pkg::*;
#(
  parameter int  KS_DEPTH = KS_DEPTH_DEF,
  parameter int  LEN_W    = 16,
  localparam int LW       = $clog2(KS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [7:0]       din_data,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [7:0]       dout_data,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    ks_level
);

  sx_state_e        state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dout_valid_q, dout_valid_d;
  byte_t            dout_data_q, dout_data_d;
  logic             dout_last_q, dout_last_d;
  logic             done_q, done_d;

  logic  fifo_full, fifo_empty, ks_push, xfer;
  byte_t ks_head;

  assign ks_ready  = !fifo_full;
  assign ks_push   = ks_valid && !fifo_full;
  assign din_ready = (state_q == ST_RUN) && (rem_q != '0) && !fifo_empty &&
                     (!dout_valid_q || dout_ready);
  assign xfer      = din_valid && din_ready;

  rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_ks_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ks_push),
    .wr_data (ks_data),
    .pop     (xfer),
    .rd_data (ks_head),
    .level   (ks_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_last_d  = dout_last_q;
    done_d       = 1'b0;

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (msg_len != '0) begin
            rem_d   = msg_len;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          dout_data_d  = din_data ^ ks_head;
          dout_valid_d = 1'b1;
          dout_last_d  = (rem_q == LEN_W'(1));
          rem_d        = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // The final byte must leave before done, so done never precedes dout_last.
        if (dout_valid_q && dout_ready) begin
          dout_last_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_last_q  <= dout_last_d;
      done_q       <= done_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_last  = dout_last_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
